// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit and pipeline control.
package fwd_hazard_unit_pkg;

  // Storage width for register addresses inside a writer record; REG_AW must not exceed it.
  localparam int unsigned REG_AW_MAX = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int unsigned FWD_SEL_RF = 0;

  // Stage indices in the shadow pipeline (index 0 is the stage right after ID).
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // One instruction's bookkeeping as it travels EX..WB.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic                  use1;
    logic                  use2;
    logic [REG_AW_MAX-1:0] rd;
    logic [REG_AW_MAX-1:0] rs1;
    logic [REG_AW_MAX-1:0] rs2;
  } wr_rec_t;

  localparam int unsigned WR_REC_W = $bits(wr_rec_t);

  // A record produces a forwardable result only if it really writes a non-zero register.
  function automatic logic is_writer(input wr_rec_t r);
    return r.valid & r.we & (r.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Priority match of one source register against a window of writer records.
// The lowest matching stage index wins, i.e. the youngest producer.
module fwd_src_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int          FIRST     = 1,
  parameter int          LAST      = 2,
  parameter bit          LOAD_ONLY = 1'b0,
  localparam int unsigned FSEL_W   = $clog2(FWD_DEPTH)
) (
  input  wr_rec_t [FWD_DEPTH-1:0] rec_i,
  input  logic [REG_AW_MAX-1:0]   src_i,
  input  logic                    en_i,
  output logic [FSEL_W-1:0]       sel_c,
  output logic                    hit_c
);

  logic [FWD_DEPTH-1:0] match;
  logic [FSEL_W-1:0]    chain [FWD_DEPTH+1];

  // Source-operand fields and out-of-window stages are not looked at here.
  logic unused_rec;
  assign unused_rec = ^rec_i;

  assign chain[FWD_DEPTH] = FSEL_W'(FWD_SEL_RF);

  // Per-stage match, then a chain from the oldest stage down so the youngest match wins.
  for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_stage
    if (g >= FIRST && g <= LAST) begin : g_in
      assign match[g] = en_i & is_writer(rec_i[g]) & (rec_i[g].rd == src_i) &
                        (~LOAD_ONLY | rec_i[g].is_load);
    end else begin : g_out
      assign match[g] = 1'b0;
    end
    assign chain[g] = match[g] ? FSEL_W'(g) : chain[g+1];
  end

  assign sel_c = chain[0];
  assign hit_c = |match;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selector and load-use stall generator driven by a shadow pipeline
// of writer records covering EX..WB (FWD_DEPTH stages).
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_DEPTH  = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FSEL_W    = $clog2(FWD_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall_id,
  output logic [FSEL_W-1:0] ex_fwd_a,
  output logic [FSEL_W-1:0] ex_fwd_b,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  wr_rec_t [FWD_DEPTH-1:0] rec_q, rec_d;
  wr_rec_t                 id_rec;
  wr_rec_t                 ex_rec;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    id_hit1, id_hit2;

  logic [FSEL_W-1:0] unused_id_sel1, unused_id_sel2;
  logic              unused_ex_hit_a, unused_ex_hit_b;

  // Pack the ID-stage instruction into a record.
  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.we      = id_reg_write;
    id_rec.is_load = id_is_load;
    id_rec.use1    = id_use_rs1;
    id_rec.use2    = id_use_rs2;
    id_rec.rd      = REG_AW_MAX'(id_rd);
    id_rec.rs1     = REG_AW_MAX'(id_rs1);
    id_rec.rs2     = REG_AW_MAX'(id_rs2);
  end

  assign ex_rec = rec_q[STG_EX];

  // Load window for ID: loads in stages 0..LOAD_READY-2 cannot forward in time yet.
  fwd_src_select #(
    .FWD_DEPTH (FWD_DEPTH),
    .FIRST     (0),
    .LAST      (int'(LOAD_READY) - 2),
    .LOAD_ONLY (1'b1)
  ) u_id_load_rs1 (
    .rec_i (rec_q),
    .src_i (REG_AW_MAX'(id_rs1)),
    .en_i  (id_use_rs1 & (id_rs1 != '0)),
    .sel_c (unused_id_sel1),
    .hit_c (id_hit1)
  );

  fwd_src_select #(
    .FWD_DEPTH (FWD_DEPTH),
    .FIRST     (0),
    .LAST      (int'(LOAD_READY) - 2),
    .LOAD_ONLY (1'b1)
  ) u_id_load_rs2 (
    .rec_i (rec_q),
    .src_i (REG_AW_MAX'(id_rs2)),
    .en_i  (id_use_rs2 & (id_rs2 != '0)),
    .sel_c (unused_id_sel2),
    .hit_c (id_hit2)
  );

  // EX operand sources: youngest writer in MEM..last tracked stage.
  fwd_src_select #(
    .FWD_DEPTH (FWD_DEPTH),
    .FIRST     (int'(STG_MEM)),
    .LAST      (int'(FWD_DEPTH) - 1),
    .LOAD_ONLY (1'b0)
  ) u_ex_src_a (
    .rec_i (rec_q),
    .src_i (ex_rec.rs1),
    .en_i  (ex_rec.valid & ex_rec.use1 & (ex_rec.rs1 != '0)),
    .sel_c (ex_fwd_a),
    .hit_c (unused_ex_hit_a)
  );

  fwd_src_select #(
    .FWD_DEPTH (FWD_DEPTH),
    .FIRST     (int'(STG_MEM)),
    .LAST      (int'(FWD_DEPTH) - 1),
    .LOAD_ONLY (1'b0)
  ) u_ex_src_b (
    .rec_i (rec_q),
    .src_i (ex_rec.rs2),
    .en_i  (ex_rec.valid & ex_rec.use2 & (ex_rec.rs2 != '0)),
    .sel_c (ex_fwd_b),
    .hit_c (unused_ex_hit_b)
  );

  // Flush wins over the load-use stall.
  assign stall_id = id_valid & ~flush & (id_hit1 | id_hit2);

  // Next state: downstream always shifts; EX takes the ID instruction or a bubble.
  always_comb begin
    rec_d                  = '0;
    cnt_d                  = cnt_q;
    rec_d[FWD_DEPTH-1:1]   = rec_q[FWD_DEPTH-2:0];
    if (id_valid & ~stall_id & ~flush) begin
      rec_d[STG_EX] = id_rec;
    end
    if (stall_id && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q <= '0;
      cnt_q <= '0;
    end else begin
      rec_q <= rec_d;
      cnt_q <= cnt_d;
    end
  end

  assign perf_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: dut0 uses defaults, dut1 uses FWD_DEPTH=4, LOAD_READY=3, CNT_W=4.
// Both share the ID inputs; each check targets the instance whose behaviour it describes.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic        flush;

  logic        stall0, stall1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut0 (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_is_load     (id_is_load),
    .flush          (flush),
    .stall_id       (stall0),
    .ex_fwd_a       (fa0),
    .ex_fwd_b       (fb0),
    .perf_stall_cnt (cnt0)
  );

  fwd_hazard_unit #(
    .FWD_DEPTH  (4),
    .LOAD_READY (3),
    .CNT_W      (4)
  ) dut1 (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_is_load     (id_is_load),
    .flush          (flush),
    .stall_id       (stall1),
    .ex_fwd_a       (fa1),
    .ex_fwd_b       (fb1),
    .perf_stall_cnt (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input int rd, input int we, input int ld,
                       input int rs1, input int u1, input int rs2, input int u2);
    id_valid     = 1'(v);
    id_rd        = 5'(rd);
    id_reg_write = 1'(we);
    id_is_load   = 1'(ld);
    id_rs1       = 5'(rs1);
    id_use_rs1   = 1'(u1);
    id_rs2       = 5'(rs2);
    id_use_rs2   = 1'(u2);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
  endtask

  // A load that is still too young must never be the selected EX source (dut0: stage 1).
  always @(negedge clk) begin
    if (!reset && fa0 == 2'd1) begin
      total++;
      assert (!dut0.rec_q[1].is_load) else begin
        bad++;
        $error("FAIL ld_early_fwd observed=%0d expected=0", dut0.rec_q[1].is_load);
      end
    end
  end

  initial begin
    // Reset held two cycles with junk on the ID inputs.
    reset = 1'b1;
    flush = 1'b0;
    drive(1, int'($urandom_range(31)), 1, 1, int'($urandom_range(31)), 1,
          int'($urandom_range(31)), 1);
    tick();
    tick();
    reset = 1'b0;
    nop();
    neg();
    chk("rst_stall0", 32'(stall0), 32'd0);
    chk("rst_fa0",    32'(fa0),    32'd0);
    chk("rst_fb0",    32'(fb0),    32'd0);
    chk("rst_cnt0",   cnt0,        32'd0);
    chk("rst_fa1",    32'(fa1),    32'd0);
    chk("rst_cnt1",   32'(cnt1),   32'd0);
    tick();

    // ALU back-to-back: add x5 then sub x6,x5,x5.
    drive(1, 5, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 6, 1, 0, 5, 1, 5, 1);
    neg();
    chk("alu_nostall0", 32'(stall0), 32'd0);
    chk("alu_nostall1", 32'(stall1), 32'd0);
    tick();
    nop();
    neg();
    chk("b2b_fa0", 32'(fa0), 32'd1);
    chk("b2b_fb0", 32'(fb0), 32'd1);
    chk("b2b_fa1", 32'(fa1), 32'd1);
    chk("b2b_fb1", 32'(fb1), 32'd1);
    tick();

    // One nop in between.
    drive(1, 5, 1, 0, 1, 1, 2, 1);
    tick();
    nop();
    tick();
    drive(1, 6, 1, 0, 5, 1, 5, 1);
    tick();
    nop();
    neg();
    chk("gap1_fa0", 32'(fa0), 32'd2);
    chk("gap1_fb0", 32'(fb0), 32'd2);
    tick();

    // Two nops in between: out of dut0's window, still in dut1's stage 3.
    drive(1, 5, 1, 0, 1, 1, 2, 1);
    tick();
    nop();
    tick();
    nop();
    tick();
    drive(1, 6, 1, 0, 5, 1, 5, 1);
    tick();
    nop();
    neg();
    chk("gap2_fa0", 32'(fa0), 32'd0);
    chk("gap2_fb0", 32'(fb0), 32'd0);
    chk("gap2_fa1", 32'(fa1), 32'd3);
    tick();

    // Youngest producer wins.
    drive(1, 7, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 7, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 8, 1, 0, 7, 1, 0, 1);
    tick();
    nop();
    neg();
    chk("young_fa0", 32'(fa0), 32'd1);
    chk("young_fb0", 32'(fb0), 32'd0);
    tick();

    // Write to x0 never forwards.
    drive(1, 0, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 8, 1, 0, 0, 1, 0, 0);
    tick();
    nop();
    neg();
    chk("x0_fa0", 32'(fa0), 32'd0);
    tick();

    // Independent operands from different stages.
    drive(1, 9, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 10, 1, 0, 1, 1, 2, 1);
    tick();
    drive(1, 11, 1, 0, 9, 1, 10, 1);
    tick();
    nop();
    neg();
    chk("indep_fa0", 32'(fa0), 32'd2);
    chk("indep_fb0", 32'(fb0), 32'd1);
    tick();

    // Load-use: lw x3 then add x4,x3,x1, held in ID while dut1 stalls.
    do_reset();
    drive(1, 3, 1, 1, 2, 1, 0, 0);
    tick();
    drive(1, 4, 1, 0, 3, 1, 1, 1);
    neg();
    chk("lu_c1_stall0", 32'(stall0), 32'd1);
    chk("lu_c1_stall1", 32'(stall1), 32'd1);
    tick();
    neg();
    chk("lu_c2_stall0", 32'(stall0), 32'd0);
    chk("lu_c2_bub_a0", 32'(fa0),    32'd0);
    chk("lu_c2_bub_b0", 32'(fb0),    32'd0);
    chk("lu_c2_stall1", 32'(stall1), 32'd1);
    tick();
    neg();
    chk("lu_c3_stall0", 32'(stall0), 32'd0);
    chk("lu_c3_stall1", 32'(stall1), 32'd0);
    chk("lu_c3_fa0",    32'(fa0),    32'd2);
    chk("lu_c3_fb0",    32'(fb0),    32'd0);
    chk("lu_c3_cnt0",   cnt0,        32'd1);
    chk("lu_c3_cnt1",   32'(cnt1),   32'd2);
    tick();
    nop();
    neg();
    chk("lu_c4_fa1",  32'(fa1),  32'd3);
    chk("lu_c4_cnt1", 32'(cnt1), 32'd2);
    chk("lu_c4_cnt0", cnt0,      32'd1);
    tick();

    // Flush on the cycle a load-use stall would assert.
    do_reset();
    drive(1, 3, 1, 1, 2, 1, 0, 0);
    tick();
    drive(1, 4, 1, 0, 3, 1, 3, 1);
    flush = 1'b1;
    neg();
    chk("fl_stall0", 32'(stall0), 32'd0);
    chk("fl_stall1", 32'(stall1), 32'd0);
    tick();
    flush = 1'b0;
    nop();
    neg();
    chk("fl_fa0",   32'(fa0),  32'd0);
    chk("fl_fb0",   32'(fb0),  32'd0);
    chk("fl_cnt0",  cnt0,      32'd0);
    chk("fl_cnt1",  32'(cnt1), 32'd0);
    tick();

    // Repeated lw x3,0(x3): dut0 stalls every other cycle, dut1 two of every three.
    do_reset();
    drive(1, 3, 1, 1, 3, 1, 0, 0);
    repeat (6) tick();
    neg();
    chk("sat6_cnt0", cnt0,      32'd3);
    chk("sat6_cnt1", 32'(cnt1), 32'd4);
    repeat (34) tick();
    neg();
    chk("sat40_cnt0", cnt0,      32'd20);
    chk("sat40_cnt1", 32'(cnt1), 32'd15);

    // Reset in the middle of traffic clears state and counters.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 4, 1, 0, 3, 1, 0, 0);
    neg();
    chk("mrst_stall0", 32'(stall0), 32'd0);
    chk("mrst_stall1", 32'(stall1), 32'd0);
    chk("mrst_cnt0",   cnt0,        32'd0);
    chk("mrst_cnt1",   32'(cnt1),   32'd0);
    chk("mrst_fa0",    32'(fa0),    32'd0);
    chk("mrst_fa1",    32'(fa1),    32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-stage forwarding selector.
- Keeps an internal shadow pipeline of writer records for EX..WB, depth set by FWD_DEPTH.
- From that state it produces per-operand forwarding selects for the EX-stage instruction and a load-use stall for the ID stage.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and also keeps a saturating stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- FWD_DEPTH, 3, tracked stages after ID: index 0=EX, 1=MEM, 2=WB, ... up to FWD_DEPTH-1; legal range 2..8.
- LOAD_READY, 2, lowest stage index at which load data is forwardable; legal range 1..FWD_DEPTH-1.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID instruction valid.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads the source.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction (branch/jump resolved).
- stall_id  out  1  hold PC and IF/ID; inject bubble into EX.
- ex_fwd_a, ex_fwd_b  out  FSEL_W = clog2(FWD_DEPTH)  operand source: 0 = register file, k = result held in stage k.
- perf_stall_cnt  out  CNT_W  cycles with stall_id=1.

Behaviour:
- Record rec[k] fields: valid, rd, we, is_load, rs1, rs2, use1, use2.
- A record is a "writer" iff valid & we & rd!=0.
- Every clock:
  - rec[k] <= rec[k-1] for k>=1.
  - rec[0] <= ID record if id_valid & !stall_id & !flush; otherwise rec[0] <= bubble (valid=0).
  - Downstream shifting never stops; this unit models only ID stalls.
- Forwarding, operand a (b is identical using rs2/use2):
  - If !rec[0].valid, !use1 or rs1==0, then ex_fwd_a=0.
  - Otherwise ex_fwd_a = the smallest k in 1..FWD_DEPTH-1 with rec[k] a writer and rec[k].rd==rec[0].rs1, else 0.
  - Youngest producer always wins.
- Forwarding outputs depend on flops only: no input-to-output path, valid in the same cycle the instruction is in EX.
- Older writers that have left the tracked stages are served by the register file, which must be write-before-read.
- stall_id = id_valid & !flush & (hit on rs1 | hit on rs2).
  - A hit is: id_use_rsX, id_rsX!=0, and some j in 0..LOAD_READY-2 with rec[j] a writer, rec[j].is_load, and rec[j].rd==id_rsX.
  - LOAD_READY=1 means stall_id is constantly 0.
  - Stall length follows naturally: the load advances one stage per cycle until it is outside the window.
  - The stall is combinational from ID inputs and state.
- flush has priority over stall_id: stall_id=0 and a bubble is inserted.
- perf_stall_cnt increments on every cycle with stall_id=1 and saturates at all-ones; it does not wrap.
- Reset (including mid-operation): all rec valid=0 and perf_stall_cnt=0 at the next edge. After that, stall_id=0 and ex_fwd_a/b=0 until new records enter.
- A writer with rd==0 never forwards and never stalls.
- A load in rec[k] with k<LOAD_READY that matches an EX operand is unreachable by construction. The unit still forwards it by the priority rule; the bench asserts it never occurs.
- A non-load writer never causes a stall.
- Matches on both operands to different stages are resolved independently.

Decomposition:
- Shared package/header holds:
  - FWD_SEL_RF = 0.
  - Stage index constants STG_EX=0, STG_MEM=1, STG_WB=2.
  - Writer-record field layout and widths, which the pipeline control also uses.
- One natural sub-module, fwd_src_select: priority match of one source address against rec[1..FWD_DEPTH-1], returning FSEL_W.
  - Instantiated twice for the EX operands.
  - A variant of the same function covers the ID-stage load window.

Test Plan:
- Reset check: reset=1 for 2 cycles while id_valid=1 with random fields -> after release stall_id=0, ex_fwd_a=ex_fwd_b=0, perf_stall_cnt=0.
- ALU back-to-back: add x5 issued, then sub reading x5/x5 -> with the sub in EX, ex_fwd_a=1 and ex_fwd_b=1. Insert one nop between them -> both 2. Insert two nops -> both 0.
- Youngest wins: x7 written in two consecutive instructions, then a reader of rs1=x7 -> ex_fwd_a=1, not 2. Reader with rs1=x0 after a write of x0 -> 0.
- Load-use, default LOAD_READY=2: lw x3 then add x4,x3,x1 -> stall_id=1 for exactly 1 cycle and a bubble enters EX. With the add in EX, ex_fwd_a=2 and perf_stall_cnt=1. With LOAD_READY=3 -> 2 stall cycles and ex_fwd_a=3 (FWD_DEPTH=4).
- Flush priority: flush=1 on the cycle a load-use stall would assert -> stall_id=0 and rec[0] is a bubble (next-cycle ex_fwd_a=ex_fwd_b=0). perf_stall_cnt is unchanged.
- Counter saturation: CNT_W=4, hold a stall-inducing pattern for 20 stall cycles -> perf_stall_cnt sticks at 15.
